// File: rtl/turbo_output_checker_if.sv
// Serial bit-stream bundle carried from the TurboInterleaver outputs to the checker.
interface turbo_output_checker_if;
  logic data_in;
  logic data_in2;
  logic valid_in;
  logic flag_long;

  modport master (output data_in, output data_in2, output valid_in, output flag_long);
  modport slave  (input  data_in, input  data_in2, input  valid_in, input  flag_long);
endinterface

// File: rtl/turbo_output_checker.sv
// Deserializes both TurboInterleaver output streams and compares each byte pair
// against a synchronous expected-result ROM, reporting progress and pass/fail.
module turbo_output_checker #(
  parameter int SHORT_BYTES = 132,
  parameter int LONG_BYTES  = 768,
  parameter int ADDR_W      = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  turbo_output_checker_if.slave stream,
  output logic [ADDR_W-1:0]     exp_addr,
  input  logic [15:0]           exp_q,
  output logic [ADDR_W-1:0]     byte_count,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  err_seen,
  output logic                  done,
  output logic                  pass
);

  localparam logic [ADDR_W-1:0] SHORT_LEN = ADDR_W'(SHORT_BYTES);
  localparam logic [ADDR_W-1:0] LONG_LEN  = ADDR_W'(LONG_BYTES);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] frame_len;
  logic [ADDR_W-1:0] byte_idx;
  logic [2:0]        bit_cnt;
  logic [7:0]        sh1, sh2;
  logic [7:0]        h1, h2;
  logic              cmp_s1, cmp_s2;

  logic [7:0]        nb1, nb2;
  logic              mismatch;
  logic [15:0]       err_next;
  logic              last_cmp;

  always_comb begin
    nb1      = {sh1[6:0], stream.data_in};
    nb2      = {sh2[6:0], stream.data_in2};
    mismatch = (h1 != exp_q[15:8]) || (h2 != exp_q[7:0]);
    err_next = err_count;
    if (cmp_s2 && mismatch && (err_count != 16'hFFFF))
      err_next = err_count + 16'd1;
    // exp_addr still holds the index of the byte being compared two cycles later
    last_cmp = cmp_s2 && (exp_addr == frame_len - 1'b1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      frame_len      <= SHORT_LEN;
      byte_idx       <= '0;
      bit_cnt        <= '0;
      sh1            <= '0;
      sh2            <= '0;
      h1             <= '0;
      h2             <= '0;
      cmp_s1         <= 1'b0;
      cmp_s2         <= 1'b0;
      exp_addr       <= '0;
      byte_count     <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_seen       <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stream.valid_in) begin
            frame_len <= stream.flag_long ? LONG_LEN : SHORT_LEN;
            sh1       <= nb1;
            sh2       <= nb2;
            bit_cnt   <= 3'd1;
            state     <= CAPTURE;
          end
        end

        CAPTURE: begin
          cmp_s1 <= 1'b0;
          cmp_s2 <= cmp_s1;
          // Stop shifting once the whole frame is captured; trailing bits are ignored.
          if (stream.valid_in && (byte_idx != frame_len)) begin
            sh1     <= nb1;
            sh2     <= nb2;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              h1       <= nb1;
              h2       <= nb2;
              exp_addr <= byte_idx;
              byte_idx <= byte_idx + 1'b1;
              cmp_s1   <= 1'b1;
            end
          end
          if (cmp_s2) begin
            byte_count <= byte_count + 1'b1;
            err_count  <= err_next;
            if (mismatch && !err_seen) begin
              err_seen       <= 1'b1;
              first_err_addr <= exp_addr;
            end
            if (last_cmp) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_next == 16'd0);
            end
          end
        end

        DONE: begin
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_output_checker.sv
// Directed bench: streams frames from byte tables into the checker against a ROM model.
module tb_turbo_output_checker;

  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] exp_addr;
  logic [15:0]       exp_q = 16'd0;
  logic [ADDR_W-1:0] byte_count;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic              err_seen;
  logic              done;
  logic              pass;

  logic [15:0] rom [0:767];
  logic [7:0]  tx1 [0:767];
  logic [7:0]  tx2 [0:767];

  int checks = 0;
  int errors = 0;

  turbo_output_checker_if sif ();

  turbo_output_checker #(.SHORT_BYTES(132), .LONG_BYTES(768), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .stream         (sif.slave),
    .exp_addr       (exp_addr),
    .exp_q          (exp_q),
    .byte_count     (byte_count),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .err_seen       (err_seen),
    .done           (done),
    .pass           (pass)
  );

  always #5 clock = ~clock;

  always @(posedge clock) exp_q <= rom[exp_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic init_data();
    for (int i = 0; i < 768; i++) begin
      logic [7:0] b;
      b = 8'(i);
      rom[i] = {b ^ 8'hA5, ~b};
      tx1[i] = b ^ 8'hA5;
      tx2[i] = ~b;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b0;
    sif.valid_in  = 1'b0;
    sif.data_in   = 1'b0;
    sif.data_in2  = 1'b0;
    sif.flag_long = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Returns with the last bit still driven (valid_in=1) during the current cycle.
  task automatic send_frame(input logic long_f, input logic gaps, input int nbits);
    sif.flag_long = long_f;
    for (int k = 0; k < nbits; k++) begin
      int bi;
      int bp;
      bi = k / 8;
      bp = 7 - (k % 8);
      @(negedge clock);
      sif.valid_in = 1'b1;
      sif.data_in  = tx1[bi][bp];
      sif.data_in2 = tx2[bi][bp];
      if (gaps && k == 100) sif.flag_long = ~long_f;
      if (gaps && (k % 5) == 4 && k != nbits - 1) begin
        @(negedge clock);
        sif.valid_in = 1'b0;
        sif.data_in  = ~sif.data_in;
        @(negedge clock);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    @(negedge clock);
    sif.valid_in = 1'b0;
    for (int c = 0; c < 20 && !done; c++) @(negedge clock);
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_result(input string tag, input int bc, input int ec, input int fa,
                              input int es, input int ps, input int ea);
    check({tag, "_byte_count"}, byte_count, bc);
    check({tag, "_err_count"}, err_count, ec);
    check({tag, "_first_err_addr"}, first_err_addr, fa);
    check({tag, "_err_seen"}, err_seen, es);
    check({tag, "_pass"}, pass, ps);
    check({tag, "_exp_addr"}, exp_addr, ea);
  endtask

  initial begin
    sif.valid_in  = 1'b0;
    sif.data_in   = 1'b0;
    sif.data_in2  = 1'b0;
    sif.flag_long = 1'b0;
    init_data();

    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_exp_addr", exp_addr, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err_addr", first_err_addr, 0);
    check("rst_err_seen", err_seen, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);

    // Short frame, all match, with exact three-cycle done latency
    do_reset();
    send_frame(1'b0, 1'b0, 1056);
    @(negedge clock);
    sif.valid_in = 1'b0;
    @(negedge clock);
    check("short_done_lat2", done, 0);
    check("short_count_lat2", byte_count, 131);
    @(negedge clock);
    check("short_done_lat3", done, 1);
    check_result("short", 132, 0, 0, 0, 1, 131);

    // Long frame with gaps and flag_long flipped mid-frame
    do_reset();
    send_frame(1'b1, 1'b1, 6144);
    wait_done("long");
    check_result("long", 768, 0, 0, 0, 1, 767);

    // Injected errors
    do_reset();
    tx2[10] = tx2[10] ^ 8'h01;
    tx1[40] = tx1[40] ^ 8'h80;
    tx1[41] = tx1[41] ^ 8'h10;
    tx2[41] = tx2[41] ^ 8'h02;
    send_frame(1'b0, 1'b0, 1056);
    wait_done("inj");
    check_result("inj", 132, 3, 10, 1, 0, 131);
    init_data();

    // Bit order: byte 0 on stream 1 is A5, MSB first
    do_reset();
    send_frame(1'b0, 1'b0, 1056);
    wait_done("order_a5");
    check_result("order_a5", 132, 0, 0, 0, 1, 131);
    do_reset();
    rom[0][15:8] = 8'hA4;
    send_frame(1'b0, 1'b0, 1056);
    wait_done("order_a4");
    check_result("order_a4", 132, 1, 0, 1, 0, 131);
    init_data();

    // Reset mid-frame, then a clean short frame
    do_reset();
    send_frame(1'b1, 1'b0, 500);
    do_reset();
    @(negedge clock);
    check("midrst_byte_count", byte_count, 0);
    send_frame(1'b0, 1'b0, 1056);
    wait_done("midrst");
    check_result("midrst", 132, 0, 0, 0, 1, 131);

    // Post-done stability
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      sif.valid_in  = 1'($urandom_range(0, 1));
      sif.data_in   = 1'($urandom_range(0, 1));
      sif.data_in2  = 1'($urandom_range(0, 1));
      sif.flag_long = ~sif.flag_long;
    end
    @(negedge clock);
    sif.valid_in = 1'b0;
    check("post_done", done, 1);
    check_result("post", 132, 0, 0, 0, 1, 131);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
